// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the register file's single rd write port between two writeback
// requesters. A is the load/MEM unit and normally wins ties. B is the
// ALU/EX result. A starvation counter makes B win the tie once A has been
// granted STARVE_MAX times in a row while B was waiting.
// A granted write is registered and appears on the rd write port one cycle
// after its handshake.
module rf_wb_arbiter #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3   // must fit in the 2-bit starvation counter
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  // requester A (load / MEM)
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_data_i,
  // requester B (ALU / EX)
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_data_i,
  // register file write port
  output logic              rd_write_enable_o,
  output logic [ADDR_W-1:0] rd_write_addr_o,
  output logic [DATA_W-1:0] rd_write_data_o,
  // debug / verification visibility
  output logic [1:0]        starve_cnt_o
);

  typedef enum logic {
    PREF_A  = 1'b0,   // A wins when both are valid
    FORCE_B = 1'b1    // B has waited long enough and wins the tie
  } state_t;

  localparam logic [1:0]        CNT_MAX = 2'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              grant_a, grant_b;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // State register: arbitration preference and starvation count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PREF_A;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode: pick at most one winner; readies depend only on valids,
  // state and flush so requesters never see a data-dependent ready.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!flush_i) begin
      case (state_q)
        PREF_A: begin
          if (a_valid_i) begin
            grant_a = 1'b1;
          end else if (b_valid_i) begin
            grant_b = 1'b1;
          end
        end
        FORCE_B: begin
          if (b_valid_i) begin
            grant_b = 1'b1;
          end else if (a_valid_i) begin
            grant_a = 1'b1;
          end
        end
        default: begin
          grant_a = 1'b0;
          grant_b = 1'b0;
        end
      endcase
    end
    a_ready_o = grant_a;
    b_ready_o = grant_b;
  end

  // Next-state logic: count A wins that made B wait, switch to FORCE_B when
  // the count reaches STARVE_MAX, and fall back to PREF_A on any B win or flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = PREF_A;
      cnt_d   = 2'd0;
    end else if (grant_b) begin
      state_d = PREF_A;
      cnt_d   = 2'd0;
    end else if (state_q == PREF_A) begin
      if (grant_a && b_valid_i) begin
        // saturate rather than wrap
        if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + 2'd1;
        end
        if (cnt_d >= CNT_MAX) begin
          state_d = FORCE_B;
        end
      end else if (!b_valid_i) begin
        // B is not waiting, so there is no starvation to track
        cnt_d = 2'd0;
      end
    end
    // FORCE_B with only A valid (or idle) holds the count and the state
  end

  // Write-port next value: x0 is hardwired zero, so a grant to it completes
  // the handshake but never enables the write. Addr/data hold when idle.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (grant_a) begin
      we_d   = (a_addr_i != ZERO_REG);
      addr_d = a_addr_i;
      data_d = a_data_i;
    end else if (grant_b) begin
      we_d   = (b_addr_i != ZERO_REG);
      addr_d = b_addr_i;
      data_d = b_data_i;
    end
  end

  // Write-port register: one-cycle-wide write the cycle after the handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign rd_write_enable_o = we_q;
  assign rd_write_addr_o   = addr_q;
  assign rd_write_data_o   = data_q;
  assign starve_cnt_o      = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios with literal checks plus a
// per-cycle comparison against a behavioural model of the arbitration rules.
module tb_rf_wb_arbiter;

  localparam int DW   = 64;
  localparam int AW   = 5;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [1:0]    scnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_addr_i(a_addr), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_addr_i(b_addr), .b_data_i(b_data),
    .rd_write_enable_o(we), .rd_write_addr_o(waddr), .rd_write_data_o(wdata),
    .starve_cnt_o(scnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // B is favoured exactly when A has already beaten a waiting B SMAX times.
  int            m_cnt;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_ga, m_gb, pref_b;

  always_comb begin
    pref_b = (m_cnt >= SMAX);
    m_ga   = !flush && a_valid && (!pref_b || !b_valid);
    m_gb   = !flush && b_valid && (pref_b || !a_valid);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_we   <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
    end else begin
      m_we <= (m_ga && a_addr != 0) || (m_gb && b_addr != 0);
      if (m_ga) begin
        m_addr <= a_addr;
        m_data <= a_data;
      end else if (m_gb) begin
        m_addr <= b_addr;
        m_data <= b_data;
      end
      if (flush || m_gb)
        m_cnt <= 0;
      else if (m_ga && b_valid && !pref_b)
        m_cnt <= (m_cnt + 1 > SMAX) ? SMAX : m_cnt + 1;
      else if (!b_valid && !pref_b)
        m_cnt <= 0;
    end
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    chk("model_a_ready", {63'd0, a_ready}, {63'd0, m_ga});
    chk("model_b_ready", {63'd0, b_ready}, {63'd0, m_gb});
    chk("model_we", {63'd0, we}, {63'd0, m_we});
    chk("model_addr", {59'd0, waddr}, {59'd0, m_addr});
    chk("model_data", wdata, m_data);
    chk("model_cnt", {62'd0, scnt}, 64'(m_cnt));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input logic fl);
    @(posedge clk); #1;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin : watchdog
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  logic [1:0] cnt_tbl [8];
  logic       ga_tbl  [8];

  initial begin
    cnt_tbl = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    ga_tbl  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", {63'd0, we}, 64'd0);
    chk("rst_addr", {59'd0, waddr}, 64'd0);
    chk("rst_data", wdata, 64'd0);
    chk("rst_cnt", {62'd0, scnt}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: async reset mid-cycle while a write is on the port and A still valid
    drive(1'b1, 5'd9, 64'h55, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #3;
    chk("t1_we_before_rst", {63'd0, we}, 64'd1);
    rst = 1'b1;
    #1;
    chk("t1_we_async", {63'd0, we}, 64'd0);
    chk("t1_addr_async", {59'd0, waddr}, 64'd0);
    chk("t1_data_async", wdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    a_valid = 1'b0;
    @(negedge clk);
    chk("t1_no_replay_0", {63'd0, we}, 64'd0);
    @(negedge clk);
    chk("t1_no_replay_1", {63'd0, we}, 64'd0);

    // 2: single A write
    drive(1'b1, 5'd5, 64'hABCD, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("t2_a_ready", {63'd0, a_ready}, 64'd1);
    idle();
    @(negedge clk);
    chk("t2_we", {63'd0, we}, 64'd1);
    chk("t2_addr", {59'd0, waddr}, 64'd5);
    chk("t2_data", wdata, 64'hABCD);
    idle();
    @(negedge clk);
    chk("t2_we_off", {63'd0, we}, 64'd0);

    // 3: starvation with both held valid
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'd3, 64'hA3, 1'b1, 5'd7, 64'hB7, 1'b0);
      @(negedge clk);
      chk($sformatf("t3_a_ready_%0d", i), {63'd0, a_ready}, {63'd0, ga_tbl[i]});
      chk($sformatf("t3_b_ready_%0d", i), {63'd0, b_ready}, {63'd0, !ga_tbl[i]});
      chk($sformatf("t3_cnt_%0d", i), {62'd0, scnt}, {62'd0, cnt_tbl[i]});
      if (i == 4) begin
        chk("t3_b_we", {63'd0, we}, 64'd1);
        chk("t3_b_addr", {59'd0, waddr}, 64'd7);
        chk("t3_b_data", wdata, 64'hB7);
      end
    end
    idle();
    idle();

    // 4: write to x0 handshakes but never enables the port
    drive(1'b0, '0, '0, 1'b1, 5'd0, 64'hFF, 1'b0);
    @(negedge clk);
    chk("t4_b_ready", {63'd0, b_ready}, 64'd1);
    idle();
    @(negedge clk);
    chk("t4_we", {63'd0, we}, 64'd0);

    // 5: flush with count at 2 and a write already registered
    drive(1'b1, 5'd3, 64'hC3, 1'b1, 5'd8, 64'hC8, 1'b0);
    drive(1'b1, 5'd3, 64'hC3, 1'b1, 5'd8, 64'hC8, 1'b0);
    drive(1'b1, 5'd3, 64'hC3, 1'b1, 5'd8, 64'hC8, 1'b1);
    @(negedge clk);
    chk("t5_cnt_pre", {62'd0, scnt}, 64'd2);
    chk("t5_a_ready", {63'd0, a_ready}, 64'd0);
    chk("t5_b_ready", {63'd0, b_ready}, 64'd0);
    chk("t5_we_in_flush", {63'd0, we}, 64'd1);
    idle();
    @(negedge clk);
    chk("t5_cnt_post", {62'd0, scnt}, 64'd0);
    chk("t5_we_post", {63'd0, we}, 64'd0);

    // 6: back-to-back A writes, B idle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(10 + i), 64'h1111 * (i + 1), 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      chk($sformatf("t6_cnt_%0d", i), {62'd0, scnt}, 64'd0);
      if (i > 0) begin
        chk($sformatf("t6_we_%0d", i - 1), {63'd0, we}, 64'd1);
        chk($sformatf("t6_addr_%0d", i - 1), {59'd0, waddr}, 64'(10 + i - 1));
        chk($sformatf("t6_data_%0d", i - 1), wdata, 64'h1111 * i);
      end
    end
    idle();
    @(negedge clk);
    chk("t6_we_3", {63'd0, we}, 64'd1);
    chk("t6_addr_3", {59'd0, waddr}, 64'd13);
    chk("t6_data_3", wdata, 64'h4444);
    idle();
    @(negedge clk);
    chk("t6_we_end", {63'd0, we}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
